// File: rtl/vga_text_ctrl_if.sv
// VRAM / font ROM bus of the text-mode VGA controller.
//   vram_addr : cell address driven by the controller
//   vram_rdn  : active-low VRAM read strobe; data returns one clock later
//   vram_data : {rsvd, blink, bg[2:0], fg[2:0], char[7:0]}
//   font_addr : {char, glyph_row}, combinational from vram_data
//   font_data : glyph row, one clock after font_addr, MSB = leftmost pixel
interface vga_text_ctrl_if #(
  parameter int ADDR_W  = 13,
  parameter int GLYPH_W = 8,
  parameter int GLYPH_H = 16
);
  logic [ADDR_W-1:0]            vram_addr;
  logic                         vram_rdn;
  logic [15:0]                  vram_data;
  logic [7+$clog2(GLYPH_H):0]   font_addr;
  logic [GLYPH_W-1:0]           font_data;

  modport master (
    output vram_addr, vram_rdn, font_addr,
    input  vram_data, font_data
  );

  modport slave (
    input  vram_addr, vram_rdn, font_addr,
    output vram_data, font_data
  );
endinterface

// File: rtl/vga_text_ctrl.sv
// Parametrised text-mode VGA controller.
// H/V timing generator, character-cell VRAM fetch, synchronous font lookup,
// per-cell fg/bg/blink attributes and a blinking underline cursor.
// Pixel pipeline: counter -> pins = 3 clocks, syncs delayed to match.
// Ports:
//   vga_clk, rst             : pixel clock, async active-high reset
//   mem (master)             : VRAM / font ROM bus
//   cursor_en/row/col        : cursor control
//   R, G, B                  : 3:3:2 colour, each channel bit replicated
//   HSYNC, VSYNC             : syncs, polarity per HS_POL / VS_POL
//   frame_start              : pulse while h_cnt = v_cnt = 0 (undelayed)
module vga_text_ctrl #(
  parameter int H_ACTIVE     = 640,
  parameter int H_FP         = 16,
  parameter int H_SYNC       = 96,
  parameter int H_BP         = 48,
  parameter int V_ACTIVE     = 480,
  parameter int V_FP         = 10,
  parameter int V_SYNC       = 2,
  parameter int V_BP         = 33,
  parameter int GLYPH_W      = 8,
  parameter int GLYPH_H      = 16,
  parameter int CURSOR_H     = 2,
  parameter int BLINK_FRAMES = 30,
  parameter int ADDR_W       = 13,
  parameter bit HS_POL       = 1'b0,
  parameter bit VS_POL       = 1'b0
) (
  input  logic             vga_clk,
  input  logic             rst,
  vga_text_ctrl_if.master  mem,
  input  logic             cursor_en,
  input  logic [5:0]       cursor_row,
  input  logic [6:0]       cursor_col,
  output logic [2:0]       R,
  output logic [2:0]       G,
  output logic [1:0]       B,
  output logic             HSYNC,
  output logic             VSYNC,
  output logic             frame_start
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int COLS    = H_ACTIVE / GLYPH_W;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int GW_L    = $clog2(GLYPH_W);
  localparam int GH_L    = $clog2(GLYPH_H);
  localparam int BW      = $clog2(BLINK_FRAMES + 1);

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

  // Stage 0: counters, row base, blink state
  logic [HW-1:0]     h_q, h_d;
  logic [VW-1:0]     v_q, v_d;
  logic [ADDR_W-1:0] row_base_q, row_base_d;
  logic [ADDR_W-1:0] addr_q;
  logic [BW-1:0]     blink_q, blink_d;
  logic              phase_q, phase_d;
  logic              h_wrap, v_wrap, act0, fetch0, hs0, vs0, cur0;

  // Stage 1 / 2 pipeline
  logic              act1_q, first1_q, cur1_q, hs1_q, vs1_q;
  logic [GW_L-1:0]   off1_q;
  logic [GH_L-1:0]   grow1_q;
  logic              act2_q, first2_q, cur2_q, hs2_q, vs2_q;
  logic [GW_L-1:0]   off2_q;
  logic [6:0]        attr_q;
  logic [GLYPH_W-1:0] glyph_q;
  logic [6:0]        gattr_q;

  // Stage 3 outputs
  logic [2:0]        r_q, g_q, r_d, g_d;
  logic [1:0]        b_q, b_d;
  logic              hs_q, vs_q;
  logic [GLYPH_W-1:0] glyph_s;
  logic [6:0]        attr_s;
  logic [2:0]        colour;
  logic              unused_rsvd;

  assign unused_rsvd = mem.vram_data[15];

  assign h_wrap = (h_q == H_LAST);
  assign v_wrap = (v_q == V_LAST);
  assign act0   = (h_q < H_ACT) && (v_q < V_ACT);
  assign fetch0 = act0 && (h_q[GW_L-1:0] == '0) && !rst;
  assign hs0    = ((h_q >= HS_BEG) && (h_q < HS_END)) ? HS_POL : ~HS_POL;
  assign vs0    = ((v_q >= VS_BEG) && (v_q < VS_END)) ? VS_POL : ~VS_POL;
  assign cur0   = cursor_en
                  && (32'(cursor_row) == 32'(v_q >> GH_L))
                  && (32'(cursor_col) == 32'(h_q >> GW_L))
                  && (32'(v_q[GH_L-1:0]) >= GLYPH_H - CURSOR_H);

  // Strobe and address are combinational from the counters so that the
  // synchronous VRAM and font ROM fit in a 3-clock pixel latency.
  assign mem.vram_rdn  = !fetch0;
  assign mem.vram_addr = fetch0 ? row_base_q + ADDR_W'(h_q >> GW_L) : addr_q;
  assign mem.font_addr = {mem.vram_data[7:0], grow1_q};
  assign frame_start   = (h_q == '0) && (v_q == '0) && !rst;

  always_comb begin
    h_d        = h_wrap ? '0 : h_q + 1'b1;
    v_d        = v_q;
    row_base_d = row_base_q;
    blink_d    = blink_q;
    phase_d    = phase_q;
    if (h_wrap) begin
      v_d = v_wrap ? '0 : v_q + 1'b1;
      if (v_wrap)
        row_base_d = '0;
      else if (&v_q[GH_L-1:0])
        row_base_d = row_base_q + ADDR_W'(COLS);
      // This edge is the one that produces frame_start; the (0,0) state
      // left by reset is not counted.
      if (v_wrap) begin
        if (blink_q == BLINK_LAST) begin
          blink_d = '0;
          phase_d = ~phase_q;
        end else begin
          blink_d = blink_q + 1'b1;
        end
      end
    end
  end

  // First pixel of a cell takes font_data/attributes straight from the
  // memories; the glyph latch supplies the remaining GLYPH_W-1 pixels.
  always_comb begin
    glyph_s = first2_q ? mem.font_data : glyph_q;
    attr_s  = first2_q ? attr_q : gattr_q;
    // ~offset == GLYPH_W-1-offset because GLYPH_W is a power of two
    if (glyph_s[~off2_q] && !(attr_s[6] && !phase_q))
      colour = attr_s[2:0];
    else
      colour = attr_s[5:3];
    if (cur2_q && phase_q)
      colour = ~colour;
    r_d = act2_q ? {3{colour[2]}} : '0;
    g_d = act2_q ? {3{colour[1]}} : '0;
    b_d = act2_q ? {2{colour[0]}} : '0;
  end

  always_ff @(posedge vga_clk or posedge rst) begin
    if (rst) begin
      h_q        <= '0;
      v_q        <= '0;
      row_base_q <= '0;
      addr_q     <= '0;
      blink_q    <= '0;
      phase_q    <= 1'b0;
      act1_q     <= 1'b0;
      first1_q   <= 1'b0;
      cur1_q     <= 1'b0;
      hs1_q      <= ~HS_POL;
      vs1_q      <= ~VS_POL;
      off1_q     <= '0;
      grow1_q    <= '0;
      act2_q     <= 1'b0;
      first2_q   <= 1'b0;
      cur2_q     <= 1'b0;
      hs2_q      <= ~HS_POL;
      vs2_q      <= ~VS_POL;
      off2_q     <= '0;
      attr_q     <= '0;
      glyph_q    <= '0;
      gattr_q    <= '0;
      r_q        <= '0;
      g_q        <= '0;
      b_q        <= '0;
      hs_q       <= ~HS_POL;
      vs_q       <= ~VS_POL;
    end else begin
      h_q        <= h_d;
      v_q        <= v_d;
      row_base_q <= row_base_d;
      addr_q     <= mem.vram_addr;
      blink_q    <= blink_d;
      phase_q    <= phase_d;
      act1_q     <= act0;
      first1_q   <= fetch0;
      cur1_q     <= cur0;
      hs1_q      <= hs0;
      vs1_q      <= vs0;
      off1_q     <= h_q[GW_L-1:0];
      grow1_q    <= v_q[GH_L-1:0];
      act2_q     <= act1_q;
      first2_q   <= first1_q;
      cur2_q     <= cur1_q;
      hs2_q      <= hs1_q;
      vs2_q      <= vs1_q;
      off2_q     <= off1_q;
      if (first1_q)
        attr_q <= mem.vram_data[14:8];
      if (first2_q) begin
        glyph_q <= mem.font_data;
        gattr_q <= attr_q;
      end
      r_q        <= r_d;
      g_q        <= g_d;
      b_q        <= b_d;
      hs_q       <= hs2_q;
      vs_q       <= vs2_q;
    end
  end

  assign R     = r_q;
  assign G     = g_q;
  assign B     = b_q;
  assign HSYNC = hs_q;
  assign VSYNC = vs_q;
endmodule

// File: tb/tb_vga_text_ctrl.sv
// Scoreboard bench for vga_text_ctrl on a reduced raster (80x38 clocks,
// 8x8 glyphs, 2-frame blink half-period) so several blink periods fit.
module tb_vga_text_ctrl;
  localparam int HA = 64, HFP = 4, HSW = 8, HBP = 4;
  localparam int VA = 32, VFP = 2, VSW = 2, VBP = 2;
  localparam int GW = 8, GH = 8, CH = 2, BF = 2, AW = 13;
  localparam int HT = HA + HFP + HSW + HBP;
  localparam int VT = VA + VFP + VSW + VBP;
  localparam int COLS = HA / GW;
  localparam int NCELL = COLS * (VA / GH);
  localparam int FRAME = HT * VT;

  logic clk = 1'b0;
  logic rst;
  logic cursor_en;
  logic [5:0] cursor_row;
  logic [6:0] cursor_col;
  logic [2:0] R, G;
  logic [1:0] B;
  logic HSYNC, VSYNC, frame_start;

  always #5 clk = ~clk;

  vga_text_ctrl_if #(.ADDR_W(AW), .GLYPH_W(GW), .GLYPH_H(GH)) mif ();

  vga_text_ctrl #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
    .GLYPH_W(GW), .GLYPH_H(GH), .CURSOR_H(CH), .BLINK_FRAMES(BF),
    .ADDR_W(AW), .HS_POL(1'b0), .VS_POL(1'b0)
  ) dut (
    .vga_clk(clk), .rst(rst), .mem(mif.master),
    .cursor_en(cursor_en), .cursor_row(cursor_row), .cursor_col(cursor_col),
    .R(R), .G(G), .B(B), .HSYNC(HSYNC), .VSYNC(VSYNC),
    .frame_start(frame_start)
  );

  logic [15:0] vram [0:NCELL-1];
  logic [7:0]  font [0:2047];

  // Synchronous VRAM and font ROM
  always @(posedge clk) begin
    if (!mif.vram_rdn) mif.vram_data <= vram[int'(mif.vram_addr) % NCELL];
    mif.font_data <= font[mif.font_addr];
  end

  int n_vec = 0;
  int n_miss = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_miss++;
      $display("FAIL %s got=%0h want=%0h", nm, got, want);
    end
  endtask

  // Reference: pixel seen at raster position (h,v) of frame f, {R,G,B,HS,VS}
  function automatic logic [9:0] model_pix(int h, int v, int f, logic ce, int cr, int cc);
    logic [15:0] w;
    logic [7:0]  g;
    logic [2:0]  c;
    logic        hs, vs;
    int          phase;
    hs = (h >= HA + HFP && h < HA + HFP + HSW) ? 1'b0 : 1'b1;
    vs = (v >= VA + VFP && v < VA + VFP + VSW) ? 1'b0 : 1'b1;
    c = 3'b000;
    if (h < HA && v < VA) begin
      w = vram[(v / GH) * COLS + h / GW];
      g = font[int'(w[7:0]) * GH + v % GH];
      phase = (f / BF) % 2;
      c = (g[GW - 1 - h % GW] && !(w[14] && phase == 0)) ? w[10:8] : w[13:11];
      if (ce && cr == v / GH && cc == h / GW && v % GH >= GH - CH && phase == 1)
        c = ~c;
    end
    return {{3{c[2]}}, {3{c[1]}}, {2{c[0]}}, hs, vs};
  endfunction

  typedef struct {
    logic [9:0] pix;
    int h;
    int v;
    int f;
  } ent_t;

  ent_t q[$];
  ent_t me, pe;
  bit   sb_run = 1'b0;
  int   mh, mv, mf;
  int   h3, v3;
  logic fetch;

  // Stimulus side: predict the pixel for the current raster position
  always @(negedge clk) begin
    if (!sb_run) begin
      mh = 0; mv = 0; mf = 0;
    end else begin
      me.pix = model_pix(mh, mv, mf, cursor_en, int'(cursor_row), int'(cursor_col));
      me.h = mh; me.v = mv; me.f = mf;
      q.push_back(me);
      mh++;
      if (mh == HT) begin
        mh = 0; mv++;
        if (mv == VT) begin mv = 0; mf++; end
      end
    end
  end

  // Monitor: once the 3-clock pipeline is full the pins carry a pixel each clock
  always @(posedge clk) begin
    #1;
    if (!sb_run) q.delete();
    else if (q.size() >= 3) begin
      pe = q.pop_front();
      chk($sformatf("pixel f=%0d v=%0d h=%0d", pe.f, pe.v, pe.h),
          32'({R, G, B, HSYNC, VSYNC}), 32'(pe.pix));
      h3 = pe.h + 3; v3 = pe.v;
      if (h3 >= HT) begin h3 -= HT; v3 = (v3 + 1) % VT; end
      fetch = (h3 < HA) && (v3 < VA) && (h3 % GW == 0);
      chk($sformatf("strobe_fs v=%0d h=%0d", v3, h3),
          32'({frame_start, mif.vram_rdn}), 32'({(h3 == 0 && v3 == 0), !fetch}));
      if (fetch)
        chk($sformatf("vram_addr v=%0d h=%0d", v3, h3),
            32'(mif.vram_addr), (v3 / GH) * COLS + h3 / GW);
    end
  end

  task automatic check_reset(input string nm);
    chk({nm, "_rgb"}, 32'({R, G, B}), 32'd0);
    chk({nm, "_syncs"}, 32'({HSYNC, VSYNC}), 32'b11);
    chk({nm, "_rdn"}, 32'(mif.vram_rdn), 32'd1);
    chk({nm, "_fs"}, 32'(frame_start), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    cursor_en = 1'b1;
    cursor_row = 6'd2;
    cursor_col = 7'd5;
    foreach (vram[i]) vram[i] = 16'($urandom);
    foreach (font[i]) font[i] = 8'($urandom);
    vram[0] = 16'h0F41;
    font[8'h41 * GH] = 8'b1000_0001;
    vram[3][14] = 1'b1;
    vram[21][14] = 1'b0;

    repeat (3) @(posedge clk);
    #1 check_reset("reset");
    @(posedge clk);
    #2 rst = 1'b0; sb_run = 1'b1;

    repeat (3 * FRAME) @(posedge clk);
    #2 cursor_col = 7'd90;
    repeat (2 * FRAME + 100) @(posedge clk);
    #2 sb_run = 1'b0; rst = 1'b1;
    #1 check_reset("midline_reset");

    repeat (4) @(posedge clk);
    #2;
    foreach (vram[i]) vram[i] = 16'($urandom);
    cursor_row = 6'($urandom_range(0, VA / GH - 1));
    cursor_col = 7'($urandom_range(0, COLS - 1));
    rst = 1'b0; sb_run = 1'b1;
    repeat (FRAME + 200) @(posedge clk);
    #2 sb_run = 1'b0;
    @(posedge clk);
    #2;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule

// File: doc/vga_text_ctrl.md
Name: vga_text_ctrl

Overview:
Parametrised text-mode VGA controller: internal H/V timing generator, character-cell VRAM fetch, synchronous font ROM lookup, per-cell foreground/background colour and blink attributes, and a hardware underline cursor with internal frame-based blink. It replaces the fixed 640x480 text display path, sits between the VRAM read port and the 3:3:2 VGA pins, and is fully pipelined with syncs re-aligned to pixels.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (clocks)
H_SYNC, 96, horizontal sync width
H_BP, 48, horizontal back porch
V_ACTIVE, 480, visible lines
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width
V_BP, 33, vertical back porch
GLYPH_W, 8, glyph width, power of 2 (8 or 16)
GLYPH_H, 16, glyph height, power of 2
CURSOR_H, 2, cursor underline height (bottom glyph rows)
BLINK_FRAMES, 30, frames per blink half-period
ADDR_W, 13, VRAM address width
HS_POL / VS_POL, 0 / 0, sync active level (0 = active-low)

Ports:
vga_clk  in  1  pixel clock
rst  in  1  asynchronous reset, active-high
vram_addr  out  ADDR_W  cell address = char_row*COLS + char_col, COLS = H_ACTIVE/GLYPH_W
vram_rdn  out  1  active-low VRAM read strobe
vram_data  in  16  cell, valid 1 clock after strobe: [7:0] char, [10:8] fg RGB, [13:11] bg RGB, [14] blink, [15] reserved
font_addr  out  8+log2(GLYPH_H)  {vram_data[7:0], glyph_row}, combinational from vram_data
font_data  in  GLYPH_W  glyph row, valid 1 clock after font_addr; MSB = leftmost pixel
cursor_en  in  1  cursor enable
cursor_row  in  6  cursor character row
cursor_col  in  7  cursor character column
R  out  3, G  out  3, B  out  2  colour, each bit replicated from 1-bit channel
HSYNC  out  1, VSYNC  out  1  syncs, polarity per HS_POL/VS_POL
frame_start  out  1  one-clock pulse when h_cnt=0 and v_cnt=0 (undelayed)

Behaviour:
- Async reset: h_cnt=v_cnt=0, row_base=0, blink counter/phase=0, vram_rdn=1, R=G=B=0, HSYNC/VSYNC at inactive level, frame_start=0, pipeline regs cleared. Reset mid-frame takes effect immediately; restart at pixel (0,0).
- Counters: h_cnt 0..H_TOTAL-1 (H_TOTAL = sum of H params = 800); at wrap v_cnt increments, wrapping at V_TOTAL-1 (525). active = h_cnt<H_ACTIVE && v_cnt<V_ACTIVE.
- Fetch stage 0: when active and h_cnt mod GLYPH_W == 0, vram_rdn=0 for one clock, vram_addr = row_base + h_cnt/GLYPH_W. Otherwise vram_rdn=1, vram_addr holds. row_base += COLS at end of the last glyph row of each character row; cleared at v wrap. No multiplier.
- Stage 1: font_addr from vram_data and glyph_row = v_cnt mod GLYPH_H; attributes registered.
- Stage 2: font_data, fg, bg, blink registered into a glyph latch held for GLYPH_W clocks.
- Stage 3: pixel bit = glyph[GLYPH_W-1-offset]; colour = bit ? fg : bg; registered to R/G/B. HSYNC, VSYNC, active are delayed 3 clocks to match. Total latency counter->pin = 3 clocks. Outside active: R=G=B=0.
- Cell blink: when attr[14]=1 and blink phase=0, output bg for all pixels of that cell.
- Blink counter increments at each frame_start; at BLINK_FRAMES-1 it clears and phase toggles.
- Cursor: when cursor_en and cell row/column match and glyph_row >= GLYPH_H-CURSOR_H and phase=1, output colour is inverted (bitwise NOT of the 3-bit colour). Cursor outside COLS/ROWS never displays.
- Syncs: HSYNC asserted for delayed h in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC); VSYNC likewise per line.

Test Plan:
- Assert rst mid-line -> same clock R=G=B=0, HSYNC=VSYNC=1, vram_rdn=1; after release, frame_start at clock 0, line period 800, frame 420000 clocks.
- Default timing -> HSYNC low for 96 clocks, starting 659 clocks after h_cnt=0; VSYNC low for exactly lines 490-491.
- Line 0 -> vram_rdn pulses at h=0,8,...,632, addresses 0..79; line 16 -> addresses 80..159; last visible line reads 2320..2399.
- Cell 0 = 0x0F41 (char 'A', fg=7, bg=1), font_data=8'b1000_0001 -> pixels 0..7 at clock 3..10: white, blue x6, white; R=G=3'b111, B=2'b11 for white.
- Cell attr[14]=1 -> shows bg only during frames 0-29, glyph during 30-59, repeating.
- cursor_en=1, row=2, col=5 -> glyph rows 14-15 of cell 165 inverted only while phase=1; cursor_col=90 -> no change to any pixel.
